// File: rtl/cbc_pkg.sv
// cbc_pkg: shared types and helpers for the 4-bit CBC stream controller.
//   NIB_W   nibble width
//   mode_e  MODE_ENC / MODE_DEC
//   state_e controller FSM states (IDLE, RUN, DRAIN)
//   swp()   bit-pair swap used by the nibble cipher
package cbc_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Swap the bits inside each pair: {x[2], x[3], x[0], x[1]}.
    function automatic logic [NIB_W-1:0] swp(input logic [NIB_W-1:0] x);
        return {x[2], x[3], x[0], x[1]};
    endfunction

endpackage

// File: rtl/cbc_nibble_core.sv
// cbc_nibble_core: combinational single-nibble CBC step.
//   data        in   input nibble (plaintext on encrypt, ciphertext on decrypt)
//   key         in   cipher key
//   chain       in   current chaining value
//   mode        in   MODE_ENC / MODE_DEC
//   out         out  resulting nibble
//   next_chain  out  chaining value for the following nibble
module cbc_nibble_core
    import cbc_pkg::*;
(
    input  logic [NIB_W-1:0] data,
    input  logic [NIB_W-1:0] key,
    input  logic [NIB_W-1:0] chain,
    input  mode_e            mode,
    output logic [NIB_W-1:0] out,
    output logic [NIB_W-1:0] next_chain
);

    always_comb begin
        out        = '0;
        next_chain = '0;
        if (mode == MODE_DEC) begin
            // Decrypt chains on the incoming ciphertext, not on the result.
            out        = swp(data) ^ key ^ chain;
            next_chain = data;
        end else begin
            out        = swp(data ^ chain ^ key);
            next_chain = swp(data ^ chain ^ key);
        end
    end

endmodule

// File: rtl/cbc_stream_ctrl.sv
// cbc_stream_ctrl: sequencer for the 4-bit CBC block cipher.
// Accepts a message of `len` nibbles on a valid/ready stream, runs each accepted nibble through
// one shared cbc_nibble_core and emits the result through a 1-entry output register.
//   clk, rst_n          clock, synchronous active-low reset
//   start, mode, key,   message setup; sampled only in IDLE
//   iv, len
//   in_valid/in_ready,  input nibble stream
//   in_data
//   out_valid/out_ready,output nibble stream; out_last marks the final nibble
//   out_data, out_last
//   busy                state != IDLE
//   done                1-cycle pulse when the final nibble has been taken by the sink
//   err                 1-cycle pulse when start is seen with len == 0
//   msg_cnt             completed-message counter, only when CBC_CTRL_CNT_EN is defined
// Optional feature macro: CBC_CTRL_CNT_EN.
module cbc_stream_ctrl
    import cbc_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [NIB_W-1:0] key,
    input  logic [NIB_W-1:0] iv,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [NIB_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [NIB_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
`ifdef CBC_CTRL_CNT_EN
    output logic             err,
    output logic [15:0]      msg_cnt
`else
    output logic             err
`endif
);

    state_e           state_q;
    mode_e            mode_q;
    logic [NIB_W-1:0] key_q;
    logic [NIB_W-1:0] chain_q;
    logic [LEN_W-1:0] rem_q;
    logic             out_valid_q;
    logic [NIB_W-1:0] out_data_q;
    logic             out_last_q;
    logic             done_q;
    logic             err_q;
`ifdef CBC_CTRL_CNT_EN
    logic [15:0]      msg_cnt_q;
`endif

    logic             in_fire;
    logic             out_fire;
    logic             last_nib;
    logic [NIB_W-1:0] core_out;
    logic [NIB_W-1:0] core_next_chain;

    cbc_nibble_core u_core (
        .data       (in_data),
        .key        (key_q),
        .chain      (chain_q),
        .mode       (mode_q),
        .out        (core_out),
        .next_chain (core_next_chain)
    );

    // The output register can take a new nibble when empty or when it drains this same cycle.
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign last_nib = (rem_q == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_ENC;
            key_q       <= '0;
            chain_q     <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CBC_CTRL_CNT_EN
            msg_cnt_q   <= 16'd0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // A refill in RUN below overrides this clear.
            if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= mode_e'(mode);
                            key_q   <= key;
                            chain_q <= iv;
                            rem_q   <= len;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        out_data_q  <= core_out;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_nib;
                        rem_q       <= rem_q - LEN_W'(1);
                        chain_q     <= core_next_chain;
                        if (last_nib) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final nibble can be pending here.
                    if (out_fire) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
`ifdef CBC_CTRL_CNT_EN
                        msg_cnt_q <= msg_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
`ifdef CBC_CTRL_CNT_EN
    assign msg_cnt   = msg_cnt_q;
`endif

endmodule

// File: tb/tb_cbc_stream_ctrl.sv
// tb_cbc_stream_ctrl: self-checking bench for cbc_stream_ctrl.
// Directed cases plus randomized messages checked against a nibble-level CBC model.
// Define CBC_CTRL_CNT_EN to also exercise the msg_cnt port.
module tb_cbc_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [3:0] key;
    logic [3:0] iv;
    logic [7:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;
`ifdef CBC_CTRL_CNT_EN
    logic [15:0] msg_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    logic [3:0] msg [256];
    logic [3:0] expq[256];
    logic [3:0] act [256];

    always #5 clk = ~clk;

    cbc_stream_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .iv        (iv),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
`ifdef CBC_CTRL_CNT_EN
        .err       (err),
        .msg_cnt   (msg_cnt)
`else
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Swap adjacent bit pairs, written arithmetically.
    function automatic logic [3:0] pairswap(input logic [3:0] x);
        return ((x & 4'hA) >> 1) | ((x & 4'h5) << 1);
    endfunction

    // Called at a negedge; returns at the negedge where done should be high.
    task automatic run_msg(input logic m, input logic [3:0] k, input logic [3:0] v, input int n,
                           input int vpct, input int rpct, input bit poke, input int stall_at);
        logic [3:0] c;
        logic [3:0] held;
        int         sent;
        int         got;
        int         cyc;
        bit         stalled;
        c = v;
        for (int i = 0; i < n; i++) begin
            if (!m) begin
                expq[i] = pairswap(msg[i] ^ c ^ k);
                c       = expq[i];
            end else begin
                expq[i] = pairswap(msg[i]) ^ k ^ c;
                c       = msg[i];
            end
        end
        start = 1'b1; mode = m; key = k; iv = v; len = 8'(n);
        @(negedge clk);
        start = 1'b0;
        key = 4'($urandom); iv = 4'($urandom); mode = 1'($urandom); len = 8'($urandom);
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = 4'h0;
        while (got < n && cyc < 2000) begin
            in_valid  = (sent < n) && (int'($urandom_range(99)) < vpct);
            in_data   = in_valid ? msg[sent] : 4'($urandom);
            out_ready = (cyc >= stall_at && cyc < stall_at + 3) ? 1'b0
                                                                : (int'($urandom_range(99)) < rpct);
            start     = poke && (cyc == 1);
            #1;
            chk("busy_run", busy, 1);
            chk("done_quiet", done, 0);
            if (stalled) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("out_data", out_data, expq[got]);
                chk("out_last", out_last, (got == n - 1));
                act[got] = out_data;
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        chk("msg_complete", got, n);
        chk("done_pulse", done, 1);
        chk("idle_after", busy, 0);
        ndone++;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; key = 4'h0; iv = 4'h0; len = 8'h0;
        in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
`ifdef CBC_CTRL_CNT_EN
        chk("rst_msg_cnt", msg_cnt, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Encrypt key=5 iv=3: A,6 -> C,F
        msg[0] = 4'hA; msg[1] = 4'h6;
        run_msg(1'b0, 4'h5, 4'h3, 2, 100, 100, 1'b0, -10);
        chk("t1_out0", act[0], 4'hC);
        chk("t1_out1", act[1], 4'hF);
        @(negedge clk);
        chk("t1_done_once", done, 0);

        // Decrypt back, then a single-nibble zero-key encrypt
        msg[0] = 4'hC; msg[1] = 4'hF;
        run_msg(1'b1, 4'h5, 4'h3, 2, 100, 100, 1'b0, -10);
        chk("t2_out0", act[0], 4'hA);
        chk("t2_out1", act[1], 4'h6);
        msg[0] = 4'h1;
        run_msg(1'b0, 4'h0, 4'h0, 1, 100, 100, 1'b0, -10);
        chk("t2_single", act[0], 4'h2);

        // Three-cycle sink stall mid-message
        for (int i = 0; i < 5; i++) msg[i] = 4'($urandom);
        run_msg(1'b0, 4'h9, 4'h4, 5, 100, 100, 1'b0, 2);

        // len == 0 rejected
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_still_idle", busy, 0);

        // start during RUN is ignored
        for (int i = 0; i < 4; i++) msg[i] = 4'($urandom);
        run_msg(1'b1, 4'h7, 4'hB, 4, 100, 100, 1'b1, -10);

        // Reset after 1 of 3 nibbles
        @(negedge clk);
        for (int i = 0; i < 3; i++) msg[i] = 4'($urandom);
        start = 1'b1; mode = 1'b0; key = 4'h6; iv = 4'hD; len = 8'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = msg[0]; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid_loaded", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        @(negedge clk);
        chk("rst_mid_no_done", done, 0);
`ifdef CBC_CTRL_CNT_EN
        ndone = 0;
        chk("rst_mid_cnt", msg_cnt, 0);
`endif
        run_msg(1'b0, 4'h6, 4'hD, 3, 100, 100, 1'b0, -10);

        // Randomized back-to-back messages
        for (int t = 0; t < 12; t++) begin
            int n;
            n = int'($urandom_range(10, 1));
            for (int i = 0; i < n; i++) msg[i] = 4'($urandom);
            run_msg(1'($urandom), 4'($urandom), 4'($urandom), n, 70, 60, 1'($urandom), -10);
        end

`ifdef CBC_CTRL_CNT_EN
        chk("msg_cnt", msg_cnt, 32'(16'(ndone)));
        @(negedge clk);
        dut.msg_cnt_q = 16'hFFFF;
        @(negedge clk);
        msg[0] = 4'h3;
        run_msg(1'b0, 4'h1, 4'h2, 1, 100, 100, 1'b0, -10);
        chk("msg_cnt_wrap", msg_cnt, 0);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
